// File: rtl/cdb_scheduler_pkg.sv
// Shared types for the common-data-bus scheduler and arbiter.
package cdb_scheduler_pkg;

    // Default number of functional units competing for the CDB.
    localparam int CDB_FU_COUNT = 3;

    // Index of one functional unit at the default FU count.
    typedef logic [$clog2(CDB_FU_COUNT)-1:0] fu_idx_t;

endpackage

// File: rtl/cdb_scheduler_rr_pick.sv
// Rotating first-one finder: returns the first set request at or after
// start_i, wrapping modulo N. When nothing is set, idx_o echoes start_i.
module cdb_scheduler_rr_pick #(
    parameter int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Scan from farthest to nearest so the nearest requester is written last.
    always_comb begin
        int c;
        idx_o   = start_i;
        found_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(start_i) + k;
            if (c >= N) c = c - N;
            if (req_i[c]) begin
                idx_o   = W'(c);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// CDB scheduler: round-robin grant with starvation override, gated by
// back-pressure and flush; keeps per-FU wait counters and perf counters.
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter int FUNCTIONAL_UNIT_COUNT = CDB_FU_COUNT,
    parameter int WAIT_W                = 4,
    parameter int STARVE_LIMIT          = 8,
    parameter int PERF_W                = 32,
    localparam int IDX_W = $clog2(FUNCTIONAL_UNIT_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [FUNCTIONAL_UNIT_COUNT-1:0] fu_status,
    input  logic                             cdb_ready,
    input  logic                             flush,
    output logic                             should_dispatch,
    output logic [IDX_W-1:0]                 victim,
    output logic                             starving,
    output logic [PERF_W-1:0]                dispatch_count,
    output logic [PERF_W-1:0]                stall_count
);

    localparam int N = FUNCTIONAL_UNIT_COUNT;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N - 1);

    logic [IDX_W-1:0]             rr_q, rr_d;
    logic [N-1:0][WAIT_W-1:0]     wait_q, wait_d;
    logic [PERF_W-1:0]            disp_q, disp_d;
    logic [PERF_W-1:0]            stall_q, stall_d;

    logic [N-1:0]                 starve_req;
    logic [IDX_W-1:0]             starve_idx;
    logic [IDX_W-1:0]             rr_idx;
    logic                         pending;

    cdb_scheduler_rr_pick #(.N(N)) u_rr_pick (
        .req_i   (fu_status),
        .start_i (rr_q),
        .idx_o   (rr_idx),
        .found_o (pending)
    );

    // Starving requesters; the lowest-indexed one wins the override.
    always_comb begin
        starve_idx = '0;
        for (int i = 0; i < N; i++)
            starve_req[i] = fu_status[i] && (wait_q[i] >= STARVE_TH);
        for (int i = N - 1; i >= 0; i--)
            if (starve_req[i]) starve_idx = IDX_W'(i);
    end

    // Grant outputs; all forced quiet while reset is held.
    always_comb begin
        should_dispatch = rst_n & cdb_ready & ~flush & pending;
        starving        = rst_n & (|starve_req);
        victim          = '0;
        if (rst_n) victim = (|starve_req) ? starve_idx : rr_idx;
    end

    // Next state: pointer past the granted FU, wait counters, perf counters.
    always_comb begin
        rr_d    = rr_q;
        disp_d  = disp_q;
        stall_d = stall_q;
        if (should_dispatch) begin
            rr_d   = (victim == LAST_IDX) ? '0 : victim + 1'b1;
            disp_d = disp_q + PERF_W'(1);
        end else if (pending) begin
            stall_d = stall_q + PERF_W'(1);
        end
        for (int i = 0; i < N; i++) begin
            if (!fu_status[i] || (should_dispatch && victim == IDX_W'(i)))
                wait_d[i] = '0;
            else if (wait_q[i] != WAIT_MAX)
                wait_d[i] = wait_q[i] + 1'b1;
            else
                wait_d[i] = wait_q[i];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q    <= '0;
            wait_q  <= '0;
            disp_q  <= '0;
            stall_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wait_q  <= wait_d;
            disp_q  <= disp_d;
            stall_q <= stall_d;
        end
    end

    assign dispatch_count = disp_q;
    assign stall_count    = stall_q;

    // Structural invariants on the grant and the pointer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (int'(victim) < N);
            assert (!should_dispatch || fu_status[victim]);
            assert (int'(rr_q) < N);
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Randomized and directed bench for cdb_scheduler with an in-bench model.
module tb_cdb_scheduler;
    import cdb_scheduler_pkg::*;

    localparam int N     = 3;
    localparam int LIMIT = 8;
    localparam int WMAX  = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  fu_status = '0;
    logic          cdb_ready = 1'b0;
    logic          flush = 1'b0;
    logic          should_dispatch;
    fu_idx_t       victim;
    logic          starving;
    logic [31:0]   dispatch_count;
    logic [31:0]   stall_count;

    cdb_scheduler #(
        .FUNCTIONAL_UNIT_COUNT(N), .WAIT_W(4), .STARVE_LIMIT(LIMIT), .PERF_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fu_status(fu_status), .cdb_ready(cdb_ready),
        .flush(flush), .should_dispatch(should_dispatch), .victim(victim),
        .starving(starving), .dispatch_count(dispatch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_rr;
    int          m_wait [N];
    bit [31:0]   m_disp, m_stall;
    int          e_v;
    bit          e_sd, e_st;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_disp = 0; m_stall = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    // Drive inputs mid-cycle, derive expected outputs from the rules, compare.
    task automatic drive(input logic [N-1:0] st, input logic rdy, input logic fl, input logic rs);
        int sv;
        bit found;
        @(negedge clk);
        fu_status = st; cdb_ready = rdy; flush = fl; rst_n = rs;
        #1;
        e_sd = rs && rdy && !fl && (st != 0);
        sv = -1;
        for (int i = 0; i < N; i++)
            if (sv < 0 && st[i] && m_wait[i] >= LIMIT) sv = i;
        e_st = rs && (sv >= 0);
        e_v = m_rr;
        found = 0;
        for (int k = 0; k < N; k++)
            if (!found && st[(m_rr + k) % N]) begin
                e_v = (m_rr + k) % N;
                found = 1;
            end
        if (sv >= 0) e_v = sv;
        if (!rs) e_v = 0;
        chk("should_dispatch", should_dispatch, e_sd);
        chk("victim", victim, e_v);
        chk("starving", starving, e_st);
        chk("dispatch_count", dispatch_count, m_disp);
        chk("stall_count", stall_count, m_stall);
    endtask

    // Advance the model across the rising edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!fu_status[i] || (e_sd && e_v == i)) m_wait[i] = 0;
                else if (m_wait[i] < WMAX) m_wait[i]++;
            end
            if (e_sd) begin
                m_rr = (e_v + 1) % N;
                m_disp++;
            end else if (fu_status != 0) begin
                m_stall++;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] st, input logic rdy, input logic fl, input logic rs);
        drive(st, rdy, fl, rs);
        tick();
    endtask

    initial begin
        logic [N-1:0] fu_reg;
        logic [N-1:0] arr;
        model_reset();

        // Reset then idle
        for (int c = 0; c < 2; c++) begin
            drive(3'b111, 1'b1, 1'b0, 1'b0);
            chk("rst_sd", should_dispatch, 0);
            chk("rst_victim", victim, 0);
            chk("rst_disp", dispatch_count, 0);
            chk("rst_stall", stall_count, 0);
            tick();
        end

        // Round-robin over all-requesting FUs
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, 1'b1, 1'b0, 1'b1);
            chk("rr_victim", victim, c % 3);
            chk("rr_sd", should_dispatch, 1);
            tick();
        end
        drive(3'b111, 1'b1, 1'b0, 1'b1);
        chk("rr_disp6", dispatch_count, 6);
        tick();
        step(3'b010, 1'b1, 1'b0, 1'b1);

        // Wrap with gaps from pointer 2
        drive(3'b011, 1'b1, 1'b0, 1'b1);
        chk("wrap_v0", victim, 0);
        tick();
        drive(3'b011, 1'b1, 1'b0, 1'b1);
        chk("wrap_v1", victim, 1);
        tick();

        // Back-pressure then flush
        for (int c = 0; c < 3; c++) begin
            drive(3'b010, 1'b0, 1'b0, 1'b1);
            chk("bp_sd", should_dispatch, 0);
            tick();
        end
        drive(3'b010, 1'b1, 1'b1, 1'b1);
        chk("flush_sd", should_dispatch, 0);
        tick();
        drive(3'b010, 1'b1, 1'b0, 1'b1);
        chk("bp_stall4", stall_count, 4);
        chk("bp_victim", victim, 1);
        chk("bp_sd_after", should_dispatch, 1);
        tick();

        // Starvation override against pointer 2
        for (int c = 0; c < 8; c++) step(3'b001, 1'b0, 1'b0, 1'b1);
        drive(3'b101, 1'b1, 1'b0, 1'b1);
        chk("starve_flag", starving, 1);
        chk("starve_victim", victim, 0);
        tick();
        drive(3'b101, 1'b1, 1'b0, 1'b1);
        chk("starve_cleared", starving, 0);
        chk("starve_rr_next", victim, 2);
        tick();

        // Saturation, then reset mid-run
        for (int c = 0; c < 20; c++) step(3'b010, 1'b0, 1'b0, 1'b1);
        chk("sat_model", m_wait[1], 15);
        drive(3'b111, 1'b0, 1'b0, 1'b1);
        chk("sat_starving", starving, 1);
        chk("sat_victim", victim, 1);
        tick();
        drive(3'b111, 1'b1, 1'b0, 1'b0);
        chk("midrst_sd", should_dispatch, 0);
        chk("midrst_starve", starving, 0);
        tick();
        drive(3'b111, 1'b1, 1'b0, 1'b1);
        chk("post_rst_victim", victim, 0);
        chk("post_rst_disp", dispatch_count, 0);
        chk("post_rst_stall", stall_count, 0);
        chk("post_rst_starve", starving, 0);
        tick();

        // Random: arbitrary input patterns
        for (int c = 0; c < 1500; c++)
            step(N'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));

        // Random: FU-like behaviour, results held until retired
        fu_reg = '0;
        for (int c = 0; c < 2000; c++) begin
            arr = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
            fu_reg = fu_reg | arr;
            drive(fu_reg, ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 299) != 0));
            tick();
            if (e_sd) fu_reg[e_v] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_scheduler.md
Name: cdb_scheduler

Overview:
- Selects which functional unit (FU) broadcasts on the common data bus (CDB) each cycle.
- Sits directly upstream of the CDB arbiter and drives its should_dispatch and victim inputs. The arbiter then muxes the chosen FU result onto the bus and pulses retiring_stations back to the FUs.
- Arbitration is round-robin with a starvation override, gated by downstream back-pressure and pipeline flush.
- Keeps saturating per-FU wait counters and wrapping performance counters.

Parameters:
- FUNCTIONAL_UNIT_COUNT, 3, number of FUs competing for the CDB; must be >= 2.
- WAIT_W, 4, width of each per-FU wait counter.
- STARVE_LIMIT, 8, wait count at or above which an FU is starving; must be < 2**WAIT_W.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fu_status  input  FUNCTIONAL_UNIT_COUNT  bit i set = FU i holds a completed result. Held until that FU retires.
- cdb_ready  input  1  downstream (ROB/RS snoop) can accept a broadcast this cycle.
- flush  input  1  pipeline flush; no broadcast this cycle.
- should_dispatch  output  1  broadcast this cycle; feeds arbiter should_dispatch.
- victim  output  $clog2(FUNCTIONAL_UNIT_COUNT)  FU index granted; feeds arbiter victim.
- starving  output  1  some FU has wait count >= STARVE_LIMIT.
- dispatch_count  output  PERF_W  total grants.
- stall_count  output  PERF_W  cycles with pending work but no grant.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: while rst_n=0 at a rising edge, all state clears on that edge.
- Registered state and reset values:
  - rr_ptr = 0
  - wait_cnt[i] = 0 for every FU
  - dispatch_count = 0
  - stall_count = 0
- Output reset values: while rst_n=0, should_dispatch=0, victim=0 and starving=0, regardless of other inputs.
- Grant logic is combinational from the current inputs and registered state; latency 0.
  - pending = |fu_status.
  - should_dispatch = rst_n & cdb_ready & ~flush & pending.
- Victim selection, evaluated every cycle:
  - If any FU has fu_status[i]=1 and wait_cnt[i] >= STARVE_LIMIT, victim = the lowest such index.
  - Otherwise victim = the first index with fu_status set, scanning rr_ptr, rr_ptr+1, … and wrapping modulo FUNCTIONAL_UNIT_COUNT.
  - If nothing is pending, victim = rr_ptr. Do not treat it as X.
- rr_ptr update on each edge where should_dispatch=1: rr_ptr <= (victim+1) mod FUNCTIONAL_UNIT_COUNT.
  - Wrap is explicit: FUNCTIONAL_UNIT_COUNT need not be a power of two, so rr_ptr never takes values >= FUNCTIONAL_UNIT_COUNT.
  - A starvation grant also advances rr_ptr this way.
- wait_cnt[i] update per edge:
  - Cleared if fu_status[i]=0, or if FU i is granted (should_dispatch=1 and victim=i).
  - Otherwise increments, saturating at 2**WAIT_W-1.
  - It increments even while flush=1 or cdb_ready=0.
- starving = rst_n & (OR over i of fu_status[i] & (wait_cnt[i] >= STARVE_LIMIT)).
- dispatch_count increments on each edge with should_dispatch=1; wraps modulo 2**PERF_W.
- stall_count increments on each edge with pending=1 and should_dispatch=0; wraps modulo 2**PERF_W.
- flush and cdb_ready=0 in the same cycle: no grant, rr_ptr unchanged, stall_count increments once.
- A granted FU clears its fu_status on the following edge via retiring_stations. The scheduler needs no lockout, since fu_status is registered in the FU.
- Reset mid-operation: pending results are kept by the FUs. After reset, arbitration restarts from rr_ptr=0 with all wait counters at zero.
- Assertions:
  - victim < FUNCTIONAL_UNIT_COUNT.
  - should_dispatch implies fu_status[victim].
  - rr_ptr is always in range.

Decomposition:
- types package additions:
  - Constant CDB_FU_COUNT, the default FUNCTIONAL_UNIT_COUNT shared with the arbiter.
  - Typedef fu_idx_t = logic [$clog2(CDB_FU_COUNT)-1:0].
- One natural sub-module: rr_pick.
  - Purely combinational rotating first-one finder.
  - Inputs: request vector, start pointer. Outputs: index, found.
  - Reusable by the issue stage.
- Wait counters, starvation override and perf counters stay in cdb_scheduler.

Test Plan:
- Reset then idle: rst_n=0 two cycles, fu_status=3'b111 -> should_dispatch=0, victim=0, both counters 0. After release, first grant is victim=0.
- Round-robin: fu_status=3'b111 held, cdb_ready=1 -> victims 0,1,2,0,…. Hold fu_status high in the bench so every FU stays requesting. After 6 cycles, dispatch_count=6.
- Wrap with gaps: rr_ptr=2, fu_status=3'b011 -> victim=0 and rr_ptr becomes 1. Next cycle fu_status=3'b011 -> victim=1.
- Back-pressure and flush: fu_status=3'b010 with cdb_ready=0 for 3 cycles, then flush=1 for 1 cycle -> should_dispatch=0 throughout and stall_count=4. Next cycle victim=1 is granted.
- Starvation: STARVE_LIMIT=8. FU0 pending with cdb_ready=0 for 8 cycles -> starving=1. Then FU0 and FU2 pending with rr_ptr=2 -> victim=0 is granted, overriding round-robin, wait_cnt[0] clears and rr_ptr becomes 1.
- Saturation and reset mid-run: FU1 blocked for 20 cycles -> wait_cnt[1] saturates at 15. Assert rst_n=0 for one edge while fu_status=3'b111 -> all counters 0 and rr_ptr=0.
